// File: rtl/ysyx_23060184_mem_stage.sv
// MEM stage of the ysyx_23060184 RV32 pipeline: issues one load/store over a
// single-outstanding data port, formats load data, and hands the bundle to MEM/WB.
module ysyx_23060184_mem_stage #(
  parameter int DATA_WIDTH        = 32,
  parameter int REG_LENGTH        = 5,
  parameter int CSR_LENGTH        = 12,
  parameter int RESULT_SRC_LENGTH = 2
) (
  input  logic                         clk,
  input  logic                         resetn,
  // EX -> MEM handshake and bundle
  input  logic                         Evalid,
  output logic                         Mready,
  input  logic                         MemReadE,
  input  logic                         MemWriteE,
  input  logic [2:0]                   MemOpE,
  input  logic                         RegWriteE,
  input  logic                         CsrWriteE,
  input  logic [RESULT_SRC_LENGTH-1:0] ResultSrcE,
  input  logic [DATA_WIDTH-1:0]        ALUResultE,
  input  logic [DATA_WIDTH-1:0]        WriteDataE,
  input  logic [DATA_WIDTH-1:0]        PCPlus4E,
  input  logic [DATA_WIDTH-1:0]        CsrReadE,
  input  logic [REG_LENGTH-1:0]        RdE,
  input  logic [CSR_LENGTH-1:0]        CsrAddrE,
  // Data memory request/response
  output logic                         dreq_valid,
  input  logic                         dreq_ready,
  output logic                         dreq_wen,
  output logic [DATA_WIDTH-1:0]        dreq_addr,
  output logic [DATA_WIDTH-1:0]        dreq_wdata,
  output logic [3:0]                   dreq_wstrb,
  input  logic                         drsp_valid,
  input  logic [DATA_WIDTH-1:0]        drsp_rdata,
  // MEM -> WB handshake and bundle
  output logic                         Mvalid,
  input  logic                         Wready,
  output logic                         RegWriteM,
  output logic                         CsrWriteM,
  output logic [RESULT_SRC_LENGTH-1:0] ResultSrcM,
  output logic [DATA_WIDTH-1:0]        ALUResultM,
  output logic [DATA_WIDTH-1:0]        PCPlus4M,
  output logic [DATA_WIDTH-1:0]        ReadDataM,
  output logic [DATA_WIDTH-1:0]        CsrReadM,
  output logic [REG_LENGTH-1:0]        RdM,
  output logic [CSR_LENGTH-1:0]        CsrAddrM
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  logic [1:0]                   r_state;
  logic                         r_mem_read;
  logic                         r_mem_write;
  logic [2:0]                   r_mem_op;
  logic [DATA_WIDTH-1:0]        r_write_data;
  logic                         r_reg_write;
  logic                         r_csr_write;
  logic [RESULT_SRC_LENGTH-1:0] r_result_src;
  logic [DATA_WIDTH-1:0]        r_alu_result;
  logic [DATA_WIDTH-1:0]        r_pc_plus4;
  logic [DATA_WIDTH-1:0]        r_read_data;
  logic [DATA_WIDTH-1:0]        r_csr_read;
  logic [REG_LENGTH-1:0]        r_rd;
  logic [CSR_LENGTH-1:0]        r_csr_addr;

  logic                         w_accept;
  logic [1:0]                   w_off;
  logic [DATA_WIDTH-1:0]        w_shifted;
  logic [DATA_WIDTH-1:0]        w_load_data;
  logic [DATA_WIDTH-1:0]        w_store_data;
  logic [3:0]                   w_store_strb;

  assign Mready   = (r_state == S_IDLE) || ((r_state == S_HOLD) && Wready);
  assign w_accept = Evalid && Mready;
  assign w_off    = r_alu_result[1:0];

  // Request fields are pure functions of latched state, so they cannot move while REQ waits.
  assign dreq_valid = (r_state == S_REQ);
  assign dreq_wen   = r_mem_write;
  assign dreq_addr  = {r_alu_result[DATA_WIDTH-1:2], 2'b00};
  assign dreq_wdata = w_store_data;
  assign dreq_wstrb = r_mem_write ? w_store_strb : 4'b0000;

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    w_store_data = r_write_data;
    w_store_strb = 4'b1111;
    case (r_mem_op)
      3'b000: begin
        w_store_data = {(DATA_WIDTH/8){r_write_data[7:0]}};
        w_store_strb = 4'b0001 << w_off;
      end
      3'b001: begin
        w_store_data = {(DATA_WIDTH/16){r_write_data[15:0]}};
        w_store_strb = 4'b0011 << {w_off[1], 1'b0};
      end
      default: ;
    endcase
  end

  always_comb begin
    w_shifted = drsp_rdata;
    case (r_mem_op[1:0])
      2'b00:   w_shifted = drsp_rdata >> {w_off, 3'b000};
      2'b01:   w_shifted = drsp_rdata >> {w_off[1], 4'b0000};
      default: ;
    endcase
  end

  always_comb begin
    w_load_data = drsp_rdata;
    case (r_mem_op)
      3'b000:  w_load_data = {{(DATA_WIDTH-8){w_shifted[7]}}, w_shifted[7:0]};
      3'b100:  w_load_data = {{(DATA_WIDTH-8){1'b0}}, w_shifted[7:0]};
      3'b001:  w_load_data = {{(DATA_WIDTH-16){w_shifted[15]}}, w_shifted[15:0]};
      3'b101:  w_load_data = {{(DATA_WIDTH-16){1'b0}}, w_shifted[15:0]};
      default: ;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_op     <= '0;
      r_write_data <= '0;
      r_reg_write  <= 1'b0;
      r_csr_write  <= 1'b0;
      r_result_src <= '0;
      r_alu_result <= '0;
      r_pc_plus4   <= '0;
      r_read_data  <= '0;
      r_csr_read   <= '0;
      r_rd         <= '0;
      r_csr_addr   <= '0;
    end else begin
      if (w_accept) begin
        r_state      <= (MemReadE || MemWriteE) ? S_REQ : S_HOLD;
        r_mem_read   <= MemReadE;
        r_mem_write  <= MemWriteE;
        r_mem_op     <= MemOpE;
        r_write_data <= WriteDataE;
        r_reg_write  <= RegWriteE;
        r_csr_write  <= CsrWriteE;
        r_result_src <= ResultSrcE;
        r_alu_result <= ALUResultE;
        r_pc_plus4   <= PCPlus4E;
        r_read_data  <= '0;
        r_csr_read   <= CsrReadE;
        r_rd         <= RdE;
        r_csr_addr   <= CsrAddrE;
      end else begin
        case (r_state)
          S_REQ:  if (dreq_ready) r_state <= S_RESP;
          S_RESP: if (drsp_valid) begin
            r_state     <= S_HOLD;
            r_read_data <= r_mem_read ? w_load_data : '0;
          end
          S_HOLD: if (Wready) r_state <= S_IDLE;
          default: ;
        endcase
      end
    end
  end

  assign Mvalid     = (r_state == S_HOLD);
  assign RegWriteM  = r_reg_write;
  assign CsrWriteM  = r_csr_write;
  assign ResultSrcM = r_result_src;
  assign ALUResultM = r_alu_result;
  assign PCPlus4M   = r_pc_plus4;
  assign ReadDataM  = r_read_data;
  assign CsrReadM   = r_csr_read;
  assign RdM        = r_rd;
  assign CsrAddrM   = r_csr_addr;

endmodule

// File: tb/tb_ysyx_23060184_mem_stage.sv
// Directed bench for the MEM stage: reset, ALU pass-through, loads, stores,
// WB back-pressure, back-to-back issue and reset during an outstanding access.
module tb_ysyx_23060184_mem_stage;

  logic        clk = 1'b0;
  logic        resetn;
  logic        Evalid, Mready;
  logic        MemReadE, MemWriteE;
  logic [2:0]  MemOpE;
  logic        RegWriteE, CsrWriteE;
  logic [1:0]  ResultSrcE;
  logic [31:0] ALUResultE, WriteDataE, PCPlus4E, CsrReadE;
  logic [4:0]  RdE;
  logic [11:0] CsrAddrE;
  logic        dreq_valid, dreq_ready, dreq_wen;
  logic [31:0] dreq_addr, dreq_wdata;
  logic [3:0]  dreq_wstrb;
  logic        drsp_valid;
  logic [31:0] drsp_rdata;
  logic        Mvalid, Wready;
  logic        RegWriteM, CsrWriteM;
  logic [1:0]  ResultSrcM;
  logic [31:0] ALUResultM, PCPlus4M, ReadDataM, CsrReadM;
  logic [4:0]  RdM;
  logic [11:0] CsrAddrM;

  int n_pass  = 0;
  int n_total = 0;

  ysyx_23060184_mem_stage dut (
    .clk(clk), .resetn(resetn),
    .Evalid(Evalid), .Mready(Mready),
    .MemReadE(MemReadE), .MemWriteE(MemWriteE), .MemOpE(MemOpE),
    .RegWriteE(RegWriteE), .CsrWriteE(CsrWriteE), .ResultSrcE(ResultSrcE),
    .ALUResultE(ALUResultE), .WriteDataE(WriteDataE), .PCPlus4E(PCPlus4E),
    .CsrReadE(CsrReadE), .RdE(RdE), .CsrAddrE(CsrAddrE),
    .dreq_valid(dreq_valid), .dreq_ready(dreq_ready), .dreq_wen(dreq_wen),
    .dreq_addr(dreq_addr), .dreq_wdata(dreq_wdata), .dreq_wstrb(dreq_wstrb),
    .drsp_valid(drsp_valid), .drsp_rdata(drsp_rdata),
    .Mvalid(Mvalid), .Wready(Wready),
    .RegWriteM(RegWriteM), .CsrWriteM(CsrWriteM), .ResultSrcM(ResultSrcM),
    .ALUResultM(ALUResultM), .PCPlus4M(PCPlus4M), .ReadDataM(ReadDataM),
    .CsrReadM(CsrReadM), .RdM(RdM), .CsrAddrM(CsrAddrM)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic rd_en, input logic wr_en, input logic [2:0] op,
                       input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd);
    Evalid     = 1'b1;
    MemReadE   = rd_en;
    MemWriteE  = wr_en;
    MemOpE     = op;
    ALUResultE = addr;
    WriteDataE = wd;
    RdE        = rd;
    RegWriteE  = rd_en || !wr_en;
    PCPlus4E   = addr + 32'd4;
  endtask

  // Run a load from accept through HOLD with immediate memory handshakes.
  task automatic run_load(input string tag, input logic [2:0] op, input logic [31:0] addr,
                          input logic [31:0] rdata, input logic [31:0] exp);
    issue(1'b1, 1'b0, op, addr, 32'h0, 5'd7);
    tick();
    Evalid = 1'b0;
    check({tag, "_dreq_valid"}, {31'd0, dreq_valid}, 32'd1);
    check({tag, "_addr"}, dreq_addr, {addr[31:2], 2'b00});
    check({tag, "_wstrb"}, {28'd0, dreq_wstrb}, 32'd0);
    dreq_ready = 1'b1;
    tick();
    dreq_ready = 1'b0;
    drsp_valid = 1'b1;
    drsp_rdata = rdata;
    tick();
    drsp_valid = 1'b0;
    check({tag, "_mvalid"}, {31'd0, Mvalid}, 32'd1);
    check({tag, "_rdata"}, ReadDataM, exp);
    tick();
  endtask

  initial begin
    resetn = 1'b0; Evalid = 1'b0; MemReadE = 1'b0; MemWriteE = 1'b0; MemOpE = 3'd0;
    RegWriteE = 1'b0; CsrWriteE = 1'b0; ResultSrcE = 2'd0; ALUResultE = '0;
    WriteDataE = '0; PCPlus4E = '0; CsrReadE = '0; RdE = '0; CsrAddrE = '0;
    dreq_ready = 1'b0; drsp_valid = 1'b0; drsp_rdata = '0; Wready = 1'b1;
    #1;
    check("rst_mready", {31'd0, Mready}, 32'd1);
    check("rst_mvalid", {31'd0, Mvalid}, 32'd0);
    check("rst_dreq_valid", {31'd0, dreq_valid}, 32'd0);
    tick(); tick();
    resetn = 1'b1;
    tick();

    // ALU op: visible one cycle after accept.
    issue(1'b0, 1'b0, 3'd0, 32'h0000_1234, 32'h0, 5'd5);
    CsrWriteE = 1'b1; CsrAddrE = 12'h305; CsrReadE = 32'h5555_0000; ResultSrcE = 2'd2;
    tick();
    Evalid = 1'b0; CsrWriteE = 1'b0;
    check("alu_mvalid", {31'd0, Mvalid}, 32'd1);
    check("alu_rd", {27'd0, RdM}, 32'd5);
    check("alu_result", ALUResultM, 32'h0000_1234);
    check("alu_rdata", ReadDataM, 32'd0);
    check("alu_pc4", PCPlus4M, 32'h0000_1238);
    check("alu_csr", {19'd0, CsrWriteM, CsrAddrM}, {19'd0, 1'b1, 12'h305});
    check("alu_csrread", CsrReadM, 32'h5555_0000);
    check("alu_rsrc", {30'd0, ResultSrcM}, 32'd2);
    tick();
    check("alu_idle", {31'd0, Mvalid}, 32'd0);

    // Byte and half loads with sign/zero extension.
    run_load("lb",  3'b000, 32'h8000_0003, 32'h80AB_CDEF, 32'hFFFF_FF80);
    run_load("lbu", 3'b100, 32'h8000_0003, 32'h80AB_CDEF, 32'h0000_0080);
    run_load("lh",  3'b001, 32'h8000_0002, 32'h9876_1234, 32'hFFFF_9876);
    run_load("lhu", 3'b101, 32'h8000_0000, 32'h9876_F234, 32'h0000_F234);
    run_load("lb1", 3'b000, 32'h8000_0001, 32'h1122_7344, 32'h0000_0073);

    // SH at offset 2, request held while dreq_ready stays low.
    issue(1'b0, 1'b1, 3'b001, 32'h0000_0102, 32'hAAAA_BEEF, 5'd0);
    tick();
    Evalid = 1'b0;
    check("sh_wdata", dreq_wdata, 32'hBEEF_BEEF);
    check("sh_wstrb", {28'd0, dreq_wstrb}, 32'h0000_000C);
    check("sh_wen", {31'd0, dreq_wen}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("sh_hold_addr", dreq_addr, 32'h0000_0100);
      check("sh_hold_valid", {31'd0, dreq_valid}, 32'd1);
    end
    dreq_ready = 1'b1;
    tick();
    dreq_ready = 1'b0;
    check("sh_resp_state", {31'd0, dreq_valid}, 32'd0);
    drsp_valid = 1'b1; drsp_rdata = 32'hFFFF_FFFF;
    tick();
    drsp_valid = 1'b0;
    check("sh_mvalid", {31'd0, Mvalid}, 32'd1);
    check("sh_rdata", ReadDataM, 32'd0);
    tick();

    // SB at offset 3.
    issue(1'b0, 1'b1, 3'b000, 32'h0000_0203, 32'h1234_56A5, 5'd0);
    tick();
    Evalid = 1'b0;
    check("sb_wdata", dreq_wdata, 32'hA5A5_A5A5);
    check("sb_wstrb", {28'd0, dreq_wstrb}, 32'h0000_0008);
    dreq_ready = 1'b1; tick(); dreq_ready = 1'b0;
    drsp_valid = 1'b1; tick(); drsp_valid = 1'b0;
    tick();

    // LW under WB back-pressure; stray responses in HOLD must not disturb ReadDataM.
    Wready = 1'b0;
    issue(1'b1, 1'b0, 3'b010, 32'h0000_0201, 32'h0, 5'd9);
    tick();
    Evalid = 1'b0;
    check("lw_wstrb", {28'd0, dreq_wstrb}, 32'd0);
    dreq_ready = 1'b1; tick(); dreq_ready = 1'b0;
    drsp_valid = 1'b1; drsp_rdata = 32'hDEAD_BEEF;
    tick();
    drsp_rdata = 32'h1111_1111;
    for (int i = 0; i < 4; i++) begin
      check("bp_mvalid", {31'd0, Mvalid}, 32'd1);
      check("bp_mready", {31'd0, Mready}, 32'd0);
      check("bp_rdata", ReadDataM, 32'hDEAD_BEEF);
      check("bp_rd", {27'd0, RdM}, 32'd9);
      tick();
    end
    drsp_valid = 1'b0;
    Wready = 1'b1;
    issue(1'b0, 1'b0, 3'd0, 32'h0000_0ABC, 32'h0, 5'd10);
    #1;
    check("bp_release_mready", {31'd0, Mready}, 32'd1);
    tick();
    check("bp_next_mvalid", {31'd0, Mvalid}, 32'd1);
    check("bp_next_rd", {27'd0, RdM}, 32'd10);
    check("bp_next_rdata", ReadDataM, 32'd0);

    // Three back-to-back ALU ops at one per cycle.
    for (int i = 0; i < 3; i++) begin
      issue(1'b0, 1'b0, 3'd0, 32'h100 + 32'(i), 32'h0, 5'(11 + i));
      tick();
      check("b2b_mvalid", {31'd0, Mvalid}, 32'd1);
      check("b2b_rd", {27'd0, RdM}, 32'(11 + i));
      check("b2b_result", ALUResultM, 32'h100 + 32'(i));
    end
    Evalid = 1'b0;
    tick();
    check("b2b_idle", {31'd0, Mvalid}, 32'd0);

    // Reset asserted while waiting in RESP.
    issue(1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'h0, 5'd17);
    tick();
    Evalid = 1'b0;
    dreq_ready = 1'b1; tick(); dreq_ready = 1'b0;
    resetn = 1'b0;
    #1;
    check("rr_mvalid", {31'd0, Mvalid}, 32'd0);
    check("rr_dreq_valid", {31'd0, dreq_valid}, 32'd0);
    check("rr_mready", {31'd0, Mready}, 32'd1);
    check("rr_rd", {27'd0, RdM}, 32'd0);
    check("rr_alu", ALUResultM, 32'd0);
    check("rr_regwrite", {31'd0, RegWriteM}, 32'd0);
    #1;
    resetn = 1'b1;
    drsp_valid = 1'b1; drsp_rdata = 32'hCAFE_F00D;
    tick();
    drsp_valid = 1'b0;
    check("rr_late_mvalid", {31'd0, Mvalid}, 32'd0);
    check("rr_late_rdata", ReadDataM, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
